// File: rtl/exec_alu_sequencer_pkg.sv
// Shared constants for the Y86-64 execute-stage sequencer: instruction codes,
// ALU control encodings, status codes and the stack pointer step.
package exec_alu_sequencer_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] FN_OP_MAX = 4'd3;

  localparam int unsigned STACK_STEP = 8;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_XOR = 2'b11
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    STAT_AOK = 2'b00,
    STAT_HLT = 2'b01,
    STAT_INS = 2'b10
  } stat_e;

  // Only conditional moves and jumps carry a meaningful Cnd.
  function automatic logic uses_cnd(input logic [3:0] icode);
    return (icode == IRRMOVQ) || (icode == IJXX);
  endfunction

endpackage

// File: rtl/exec_alu_sequencer_if.sv
// Bundle of decode input, ALU initiator, memory-stage output and CC signals.
// master = the sequencer, slave = its environment (decode, ALU, memory stage).
interface exec_alu_sequencer_if #(
  parameter int W = 64
);
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   icode;
  logic [3:0]   ifun;
  logic [W-1:0] valA;
  logic [W-1:0] valB;
  logic [W-1:0] valC;
  logic         flush;
  logic [1:0]   alu_ctrl;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [W-1:0] alu_out;
  logic         alu_of;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_valE;
  logic         out_cnd;
  logic [3:0]   out_icode;
  logic [1:0]   out_stat;
  logic         cc_zf;
  logic         cc_sf;
  logic         cc_of;

  modport master (
    input  in_valid, icode, ifun, valA, valB, valC, flush, alu_out, alu_of, out_ready,
    output in_ready, alu_ctrl, alu_a, alu_b, out_valid, out_valE, out_cnd, out_icode,
           out_stat, cc_zf, cc_sf, cc_of
  );

  modport slave (
    output in_valid, icode, ifun, valA, valB, valC, flush, alu_out, alu_of, out_ready,
    input  in_ready, alu_ctrl, alu_a, alu_b, out_valid, out_valE, out_cnd, out_icode,
           out_stat, cc_zf, cc_sf, cc_of
  );
endinterface

// File: rtl/exec_alu_sequencer_cond_eval.sv
// Y86 condition evaluation from ZF/SF/OF; flags function codes above 6 as invalid.
module exec_alu_sequencer_cond_eval (
  input  logic [3:0] i_ifun,
  input  logic       i_zf,
  input  logic       i_sf,
  input  logic       i_of,
  output logic       o_cnd,
  output logic       o_invalid
);
  logic w_lt;

  assign w_lt = i_sf ^ i_of;

  always_comb begin
    o_cnd     = 1'b0;
    o_invalid = 1'b0;
    case (i_ifun)
      4'd0:    o_cnd = 1'b1;
      4'd1:    o_cnd = w_lt | i_zf;
      4'd2:    o_cnd = w_lt;
      4'd3:    o_cnd = i_zf;
      4'd4:    o_cnd = ~i_zf;
      4'd5:    o_cnd = ~w_lt;
      4'd6:    o_cnd = ~w_lt & ~i_zf;
      default: o_invalid = 1'b1;
    endcase
  end
endmodule

// File: rtl/exec_alu_sequencer.sv
// Execute-stage front end: drives the external ALU, keeps the condition codes
// and hands results to the memory stage through a one-entry valid/ready register.
module exec_alu_sequencer #(
  parameter int          W          = 64,
  parameter int unsigned STACK_STEP = exec_alu_sequencer_pkg::STACK_STEP
) (
  input logic                  clk,
  input logic                  rst,
  exec_alu_sequencer_if.master io_bus
);
  import exec_alu_sequencer_pkg::*;

  alu_ctrl_e    w_ctrl;
  logic [W-1:0] w_a;
  logic [W-1:0] w_b;
  logic [W-1:0] w_step;
  logic [W-1:0] w_neg_step;
  stat_e        w_stat;
  logic         w_in_ready;
  logic         w_accept;
  logic         w_commit;
  logic         w_cc_upd;
  logic         w_cnd_raw;
  logic         w_cnd_inv;
  logic         w_cnd;

  logic         r_vld_p1;
  logic [W-1:0] r_valE_p1;
  logic         r_cnd_p1;
  logic [3:0]   r_icode_p1;
  stat_e        r_stat_p1;
  logic         r_halted;
  logic         r_zf;
  logic         r_sf;
  logic         r_of;

  assign w_step     = W'(STACK_STEP);
  assign w_neg_step = ~w_step + 1'b1;

  // Stage 0: operand/control selection, condition and status decode
  always_comb begin
    w_ctrl = ALU_ADD;
    w_a    = '0;
    w_b    = '0;
    case (io_bus.icode)
      IOPQ: begin
        w_ctrl = alu_ctrl_e'(io_bus.ifun[1:0]);
        w_a    = io_bus.valB;
        w_b    = io_bus.valA;
      end
      IRRMOVQ:          w_a = io_bus.valA;
      IIRMOVQ:          w_a = io_bus.valC;
      IRMMOVQ, IMRMOVQ: begin
        w_a = io_bus.valB;
        w_b = io_bus.valC;
      end
      ICALL, IPUSHQ: begin
        w_a = io_bus.valB;
        w_b = w_neg_step;
      end
      IRET, IPOPQ: begin
        w_a = io_bus.valB;
        w_b = w_step;
      end
      default: ;
    endcase
  end

  exec_alu_sequencer_cond_eval u_cond_eval (
    .i_ifun    (io_bus.ifun),
    .i_zf      (r_zf),
    .i_sf      (r_sf),
    .i_of      (r_of),
    .o_cnd     (w_cnd_raw),
    .o_invalid (w_cnd_inv)
  );

  assign w_cnd = uses_cnd(io_bus.icode) & w_cnd_raw;

  always_comb begin
    w_stat = STAT_AOK;
    if (io_bus.icode == IHALT) begin
      w_stat = STAT_HLT;
    end else if ((io_bus.icode > IPOPQ) ||
                 ((io_bus.icode == IOPQ) && (io_bus.ifun > FN_OP_MAX)) ||
                 (uses_cnd(io_bus.icode) && w_cnd_inv)) begin
      w_stat = STAT_INS;
    end
  end

  assign w_in_ready = ~r_halted & (~r_vld_p1 | io_bus.out_ready);
  assign w_accept   = io_bus.in_valid & w_in_ready;
  assign w_commit   = w_accept & ~io_bus.flush;
  assign w_cc_upd   = w_commit & (io_bus.icode == IOPQ) & (io_bus.ifun <= FN_OP_MAX);

  // Stage 1: result register, condition codes and sticky halt
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1   <= 1'b0;
      r_valE_p1  <= '0;
      r_cnd_p1   <= 1'b0;
      r_icode_p1 <= '0;
      r_stat_p1  <= STAT_AOK;
      r_halted   <= 1'b0;
      r_zf       <= 1'b1;
      r_sf       <= 1'b0;
      r_of       <= 1'b0;
    end else begin
      if (io_bus.flush) begin
        r_vld_p1 <= 1'b0;
      end else if (w_accept) begin
        r_vld_p1 <= 1'b1;
      end else if (io_bus.out_ready) begin
        r_vld_p1 <= 1'b0;
      end

      if (w_commit) begin
        r_valE_p1  <= io_bus.alu_out;
        r_cnd_p1   <= w_cnd;
        r_icode_p1 <= io_bus.icode;
        r_stat_p1  <= w_stat;
        if (w_stat != STAT_AOK) begin
          r_halted <= 1'b1;
        end
      end

      if (w_cc_upd) begin
        r_zf <= (io_bus.alu_out == '0);
        r_sf <= io_bus.alu_out[W-1];
        r_of <= io_bus.alu_of;
      end
    end
  end

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.alu_ctrl  = w_ctrl;
  assign io_bus.alu_a     = w_a;
  assign io_bus.alu_b     = w_b;
  assign io_bus.out_valid = r_vld_p1;
  assign io_bus.out_valE  = r_valE_p1;
  assign io_bus.out_cnd   = r_cnd_p1;
  assign io_bus.out_icode = r_icode_p1;
  assign io_bus.out_stat  = r_stat_p1;
  assign io_bus.cc_zf     = r_zf;
  assign io_bus.cc_sf     = r_sf;
  assign io_bus.cc_of     = r_of;

endmodule

// File: tb/tb_exec_alu_sequencer.sv
// Randomized bench for exec_alu_sequencer against a behavioural Y86 execute model,
// with a simple combinational ALU standing in for the real one.
module tb_exec_alu_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exec_alu_sequencer_if #(.W(64)) bus ();

  exec_alu_sequencer #(.W(64)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  // Stand-in ALU: classic sign-bit overflow rules
  always_comb begin
    bus.alu_of = 1'b0;
    case (bus.alu_ctrl)
      2'b00: begin
        bus.alu_out = bus.alu_a + bus.alu_b;
        bus.alu_of  = (bus.alu_a[63] == bus.alu_b[63]) && (bus.alu_out[63] != bus.alu_a[63]);
      end
      2'b01: begin
        bus.alu_out = bus.alu_a - bus.alu_b;
        bus.alu_of  = (bus.alu_a[63] != bus.alu_b[63]) && (bus.alu_out[63] != bus.alu_a[63]);
      end
      2'b10:   bus.alu_out = bus.alu_a & bus.alu_b;
      default: bus.alu_out = bus.alu_a ^ bus.alu_b;
    endcase
  end

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state
  logic        m_valid, m_cnd, m_zf, m_sf, m_of, m_halted;
  logic [63:0] m_valE;
  logic [3:0]  m_icode;
  logic [1:0]  m_stat;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_valid = 0; m_cnd = 0; m_valE = 0; m_icode = 0; m_stat = 0;
    m_zf = 1; m_sf = 0; m_of = 0; m_halted = 0;
  endtask

  function automatic logic [64:0] sx(input logic [63:0] x);
    return {x[63], x};
  endfunction

  // Instruction semantics in plain arithmetic; of is the true signed overflow
  task automatic ref_exec(input logic [3:0] ic, fn, input logic [63:0] a, b, c,
                          output logic [63:0] r, output logic of);
    logic [64:0] w;
    of = 0;
    r  = 0;
    case (ic)
      4'h6: case (fn[1:0])
        2'd0: begin w = sx(b) + sx(a); r = w[63:0]; of = w[64] ^ w[63]; end
        2'd1: begin w = sx(b) - sx(a); r = w[63:0]; of = w[64] ^ w[63]; end
        2'd2: r = b & a;
        default: r = b ^ a;
      endcase
      4'h2: r = a;
      4'h3: r = c;
      4'h4, 4'h5: r = b + c;
      4'h8, 4'hA: r = b - 64'd8;
      4'h9, 4'hB: r = b + 64'd8;
      default: r = 0;
    endcase
  endtask

  task automatic exp_ops(input logic [3:0] ic, fn, input logic [63:0] a, b, c,
                         output logic [1:0] ec, output logic [63:0] ea, eb);
    ec = 2'b00; ea = 0; eb = 0;
    case (ic)
      4'h6: begin ec = fn[1:0]; ea = b; eb = a; end
      4'h2: ea = a;
      4'h3: ea = c;
      4'h4, 4'h5: begin ea = b; eb = c; end
      4'h8, 4'hA: begin ea = b; eb = 64'hFFFF_FFFF_FFFF_FFF8; end
      4'h9, 4'hB: begin ea = b; eb = 64'd8; end
      default: ;
    endcase
  endtask

  function automatic logic [1:0] ref_stat(input logic [3:0] ic, fn);
    if (ic == 0) return 2'b01;
    if (ic > 4'hB) return 2'b10;
    if (ic == 4'h6 && fn > 3) return 2'b10;
    if ((ic == 4'h2 || ic == 4'h7) && fn > 6) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic ref_cnd(input logic [3:0] ic, fn);
    logic lt;
    lt = m_sf ^ m_of;
    if (!(ic == 4'h2 || ic == 4'h7)) return 1'b0;
    case (fn)
      4'd0: return 1'b1;
      4'd1: return lt | m_zf;
      4'd2: return lt;
      4'd3: return m_zf;
      4'd4: return !m_zf;
      4'd5: return !lt;
      4'd6: return !lt && !m_zf;
      default: return 1'b0;
    endcase
  endfunction

  task automatic step(input logic v, input logic [3:0] ic, fn,
                      input logic [63:0] a, b, c, input logic fl, ordy, rs);
    logic [63:0] r, ea, eb;
    logic [1:0]  ec, st;
    logic        o, acc, cn;
    @(negedge clk);
    bus.in_valid = v; bus.icode = ic; bus.ifun = fn;
    bus.valA = a; bus.valB = b; bus.valC = c;
    bus.flush = fl; bus.out_ready = ordy; rst = rs;
    #1;
    acc = v && !m_halted && (!m_valid || ordy);
    check_val("in_ready", bus.in_ready, !m_halted && (!m_valid || ordy));
    if (v) begin
      exp_ops(ic, fn, a, b, c, ec, ea, eb);
      check_val("alu_ctrl", bus.alu_ctrl, ec);
      check_val("alu_a", bus.alu_a, ea);
      check_val("alu_b", bus.alu_b, eb);
    end
    ref_exec(ic, fn, a, b, c, r, o);
    st = ref_stat(ic, fn);
    cn = ref_cnd(ic, fn);
    @(posedge clk);
    #1;
    if (rs) begin
      m_reset();
    end else begin
      if (fl) m_valid = 0;
      else if (acc) m_valid = 1;
      else if (ordy) m_valid = 0;
      if (acc && !fl) begin
        m_valE = r; m_cnd = cn; m_icode = ic; m_stat = st;
        if (st != 0) m_halted = 1;
        if (ic == 4'h6 && fn <= 3) begin
          m_zf = (r == 0); m_sf = r[63]; m_of = o;
        end
      end
    end
    check_val("out_valid", bus.out_valid, m_valid);
    if (m_valid) begin
      check_val("out_valE", bus.out_valE, m_valE);
      check_val("out_cnd", bus.out_cnd, m_cnd);
      check_val("out_icode", bus.out_icode, m_icode);
      check_val("out_stat", bus.out_stat, m_stat);
    end
    check_val("cc_zf", bus.cc_zf, m_zf);
    check_val("cc_sf", bus.cc_sf, m_sf);
    check_val("cc_of", bus.cc_of, m_of);
  endtask

  task automatic go(input logic [3:0] ic, fn, input logic [63:0] a, b, c);
    step(1'b1, ic, fn, a, b, c, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [63:0] held;
    logic [63:0] a, b, c;
    logic [3:0]  ic, fn;
    int p;
    bus.in_valid = 0; bus.icode = 0; bus.ifun = 0;
    bus.valA = 0; bus.valB = 0; bus.valC = 0;
    bus.flush = 0; bus.out_ready = 1;
    rst = 1;
    repeat (2) @(posedge clk);
    m_reset();

    step(1'b0, 4'h1, 4'h0, 0, 0, 0, 1'b0, 1'b1, 1'b1);
    check_val("rst_valE", bus.out_valE, 64'd0);
    check_val("rst_stat", bus.out_stat, 2'b00);
    check_val("rst_in_ready", bus.in_ready, 1'b1);

    go(4'h6, 4'h1, 64'd5, 64'd5, 64'd0);
    check_val("sub_valE", bus.out_valE, 64'd0);
    check_val("sub_zf", bus.cc_zf, 1'b1);

    go(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0);
    check_val("ovf_valE", bus.out_valE, 64'hFFFF_FFFF_FFFF_FFFE);
    check_val("ovf_sf", bus.cc_sf, 1'b1);
    check_val("ovf_of", bus.cc_of, 1'b1);
    go(4'h7, 4'h1, 64'd0, 64'd0, 64'h40);
    check_val("jle_cc_keep", {bus.cc_zf, bus.cc_sf, bus.cc_of}, 3'b011);

    go(4'hA, 4'h0, 64'd1, 64'h100, 64'd0);
    check_val("push_valE", bus.out_valE, 64'hF8);
    go(4'hB, 4'h0, 64'd1, 64'hF8, 64'd0);
    check_val("pop_valE", bus.out_valE, 64'h100);
    check_val("pop_cc_keep", {bus.cc_zf, bus.cc_sf, bus.cc_of}, 3'b011);

    go(4'h3, 4'h0, 64'd0, 64'd0, 64'h1234);
    held = bus.out_valE;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'h3, 4'h0, 0, 0, 64'h5678, 1'b0, 1'b0, 1'b0);
      check_val("stall_hold", bus.out_valE, held);
    end
    go(4'h3, 4'h0, 64'd0, 64'd0, 64'h5678);
    check_val("resume_1", bus.out_valE, 64'h5678);
    go(4'h3, 4'h0, 64'd0, 64'd0, 64'h9ABC);
    check_val("resume_2", bus.out_valE, 64'h9ABC);

    go(4'h0, 4'h0, 0, 0, 0);
    check_val("halt_stat", bus.out_stat, 2'b01);
    go(4'h1, 4'h0, 0, 0, 0);
    check_val("halt_rdy", bus.in_ready, 1'b0);
    step(1'b0, 4'h1, 4'h0, 0, 0, 0, 1'b0, 1'b1, 1'b1);
    check_val("unhalt_rdy", bus.in_ready, 1'b1);
    go(4'hC, 4'h0, 0, 0, 0);
    check_val("ins_stat", bus.out_stat, 2'b10);
    step(1'b0, 4'h1, 4'h0, 0, 0, 0, 1'b0, 1'b1, 1'b1);

    for (int n = 0; n < 1500; n++) begin
      p = $urandom_range(0, 99);
      if (p < 3) ic = 4'h0;
      else if (p < 6) ic = 4'($urandom_range(12, 15));
      else ic = 4'($urandom_range(1, 11));
      if ($urandom_range(0, 19) == 0) fn = 4'($urandom_range(0, 15));
      else if (ic == 4'h6) fn = 4'($urandom_range(0, 3));
      else fn = 4'($urandom_range(0, 6));
      a = {$urandom, $urandom};
      b = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
      c = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 255)) : {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) a = 64'($urandom_range(0, 3));
      step($urandom_range(0, 3) != 0, ic, fn, a, b, c,
           $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7,
           m_halted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
